vga_scaler: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA output block.
- Generates VGA sync timing from a configurable timing set and pixel-clock divider.
- Fetches a low-resolution framebuffer with independent integer X/Y scale factors, multi-bit colour and a configurable framebuffer read latency.
- Adds a frame-start pulse, a vblank flag and right/bottom border blanking; sits between the framebuffer RAM and the VGA pins.

---
 rtl/vga_scaler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_vga_scaler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaler.sv
// vga_scaler: VGA sync generator that fetches an integer-scaled framebuffer.
// Optional feature macro VGA_VBLANK_IRQ_EN adds a vblank interrupt (irq / irq_ack).
module vga_scaler #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int X_SCALE    = 3,
  parameter int Y_SCALE    = 3,
  parameter int FB_WIDTH   = 214,
  parameter int FB_HEIGHT  = 160,
  parameter int FB_ADDR_W  = 16,
  parameter int BPC        = 1,
  parameter int FB_LATENCY = 1,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_async,
  input  logic                 en,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic                 fb_rd,
  input  logic [3*BPC-1:0]     fb_pixel,
  output logic [BPC-1:0]       vga_r,
  output logic [BPC-1:0]       vga_g,
  output logic [BPC-1:0]       vga_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 frame_start,
  output logic                 vblank
`ifdef VGA_VBLANK_IRQ_EN
  ,
  output logic                 irq,
  input  logic                 irq_ack
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SXW = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
  localparam int SYW = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
  localparam int FXW = $clog2(((H_VISIBLE > FB_WIDTH) ? H_VISIBLE : FB_WIDTH) + 1);
  localparam int FYW = $clog2(((V_VISIBLE > FB_HEIGHT) ? V_VISIBLE : FB_HEIGHT) + 1);

  localparam logic [DW-1:0]        DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]        H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]        H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0]        HS_BEG   = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0]        HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]        V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]        V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0]        VS_BEG   = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0]        VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [SXW-1:0]       SX_LAST  = SXW'(X_SCALE - 1);
  localparam logic [SYW-1:0]       SY_LAST  = SYW'(Y_SCALE - 1);
  localparam logic [FXW-1:0]       FB_W_X   = FXW'(FB_WIDTH);
  localparam logic [FYW-1:0]       FB_H_Y   = FYW'(FB_HEIGHT);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(FB_WIDTH);

  if (FB_WIDTH * FB_HEIGHT > 2 ** FB_ADDR_W) begin : g_bad_fb_size
    $error("vga_scaler: FB_WIDTH*FB_HEIGHT exceeds the FB_ADDR_W address space");
  end
  if (CLK_DIV < 1 || X_SCALE < 1 || Y_SCALE < 1 || FB_LATENCY < 1) begin : g_bad_param
    $error("vga_scaler: CLK_DIV, X_SCALE, Y_SCALE and FB_LATENCY must be >= 1");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic valid;
    logic fs;
    logic vb;
  } flags_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic fs;
    logic vb;
  } out_t;

  logic [DW-1:0]        div_q, div_d;
  logic [HW-1:0]        h_q, h_d;
  logic [VW-1:0]        v_q, v_d;
  logic [SXW-1:0]       sub_x_q, sub_x_d;
  logic [FXW-1:0]       fb_x_q, fb_x_d;
  logic [SYW-1:0]       sub_y_q, sub_y_d;
  logic [FYW-1:0]       fb_y_q, fb_y_d;
  logic [FB_ADDR_W-1:0] row_base_q, row_base_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  flags_t               flags_a_q, flags_a_d;
  flags_t               pipe_q [FB_LATENCY];
  flags_t               pipe_d [FB_LATENCY];
  out_t                 out_q, out_d;
  logic [3*BPC-1:0]     colour_q, colour_d;
  logic                 pix_tick;
  logic                 visible;
  logic                 valid;

  // Timing and scale counters; sub_x/fb_x restart at every line start.
  always_comb begin
    div_d      = div_q;
    h_d        = h_q;
    v_d        = v_q;
    sub_x_d    = sub_x_q;
    fb_x_d     = fb_x_q;
    sub_y_d    = sub_y_q;
    fb_y_d     = fb_y_q;
    row_base_d = row_base_q;
    pix_tick   = (div_q == DIV_LAST);
    if (!en) begin
      div_d      = '0;
      h_d        = '0;
      v_d        = '0;
      sub_x_d    = '0;
      fb_x_d     = '0;
      sub_y_d    = '0;
      fb_y_d     = '0;
      row_base_d = '0;
    end else begin
      div_d = pix_tick ? '0 : div_q + DW'(1);
      if (pix_tick) begin
        if (h_q == H_LAST) begin
          h_d     = '0;
          sub_x_d = '0;
          fb_x_d  = '0;
          if (v_q == V_LAST) begin
            v_d        = '0;
            sub_y_d    = '0;
            fb_y_d     = '0;
            row_base_d = '0;
          end else begin
            v_d = v_q + VW'(1);
            if (v_q < V_VIS) begin
              if (sub_y_q == SY_LAST) begin
                sub_y_d    = '0;
                fb_y_d     = fb_y_q + FYW'(1);
                row_base_d = row_base_q + ROW_STEP;
              end else begin
                sub_y_d = sub_y_q + SYW'(1);
              end
            end
          end
        end else begin
          h_d = h_q + HW'(1);
          if (h_q < H_VIS) begin
            if (sub_x_q == SX_LAST) begin
              sub_x_d = '0;
              fb_x_d  = fb_x_q + FXW'(1);
            end else begin
              sub_x_d = sub_x_q + SXW'(1);
            end
          end
        end
      end
    end
  end

  // Address stage: the address and the per-pixel flags are registered together.
  always_comb begin
    visible   = (h_q < H_VIS) && (v_q < V_VIS);
    valid     = visible && (fb_x_q < FB_W_X) && (fb_y_q < FB_H_Y);
    flags_a_d = '0;
    fb_addr_d = fb_addr_q;
    if (en) begin
      flags_a_d.hs    = (h_q >= HS_BEG) && (h_q <= HS_END);
      flags_a_d.vs    = (v_q >= VS_BEG) && (v_q <= VS_END);
      flags_a_d.valid = valid;
      flags_a_d.fs    = (h_q == '0) && (v_q == '0) && (div_q == '0);
      flags_a_d.vb    = (v_q >= V_VIS);
      if (valid) fb_addr_d = row_base_q + FB_ADDR_W'(fb_x_q);
    end
  end

  // Flags ride FB_LATENCY stages so valid meets fb_pixel; one more stage for the output register.
  always_comb begin
    pipe_d[0] = flags_a_q;
    for (int k = 1; k < FB_LATENCY; k++) pipe_d[k] = pipe_q[k-1];
    out_d.hs = pipe_q[FB_LATENCY-1].hs;
    out_d.vs = pipe_q[FB_LATENCY-1].vs;
    out_d.fs = pipe_q[FB_LATENCY-1].fs;
    out_d.vb = pipe_q[FB_LATENCY-1].vb;
    colour_d = pipe_q[FB_LATENCY-1].valid ? fb_pixel : '0;
    if (!en) begin
      for (int k = 0; k < FB_LATENCY; k++) pipe_d[k] = '0;
      out_d    = '0;
      colour_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      sub_x_q    <= '0;
      fb_x_q     <= '0;
      sub_y_q    <= '0;
      fb_y_q     <= '0;
      row_base_q <= '0;
      fb_addr_q  <= '0;
      flags_a_q  <= '0;
      for (int k = 0; k < FB_LATENCY; k++) pipe_q[k] <= '0;
      out_q      <= '0;
      colour_q   <= '0;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      sub_x_q    <= sub_x_d;
      fb_x_q     <= fb_x_d;
      sub_y_q    <= sub_y_d;
      fb_y_q     <= fb_y_d;
      row_base_q <= row_base_d;
      fb_addr_q  <= fb_addr_d;
      flags_a_q  <= flags_a_d;
      for (int k = 0; k < FB_LATENCY; k++) pipe_q[k] <= pipe_d[k];
      out_q      <= out_d;
      colour_q   <= colour_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd       = flags_a_q.valid;
  assign vga_r       = colour_q[3*BPC-1:2*BPC];
  assign vga_g       = colour_q[2*BPC-1:BPC];
  assign vga_b       = colour_q[BPC-1:0];
  assign vga_hsync   = out_q.hs ? SYNC_POL : ~SYNC_POL;
  assign vga_vsync   = out_q.vs ? SYNC_POL : ~SYNC_POL;
  assign frame_start = out_q.fs;
  assign vblank      = out_q.vb;

`ifdef VGA_VBLANK_IRQ_EN
  // irq is a level raised on the output cycle where vblank rises; it stays up while
  // irq_ack is low, and a new rising edge in the same cycle as irq_ack keeps it set.
  logic irq_q, irq_d, irq_set;

  always_comb begin
    irq_set = pipe_q[FB_LATENCY-1].vb && !out_q.vb;
    irq_d   = irq_q;
    if (!en)          irq_d = 1'b0;
    else if (irq_set) irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_scaler.sv
// Directed bench for vga_scaler on a reduced 24x17-pixel timing set with a 2-cycle framebuffer.
module tb_vga_scaler;

  logic       clk       = 1'b0;
  logic       rst_async = 1'b1;
  logic       en        = 1'b0;
  logic [7:0] fb_addr;
  logic       fb_rd;
  logic [5:0] fb_pixel;
  logic [1:0] vga_r, vga_g, vga_b;
  logic       vga_hsync, vga_vsync, frame_start, vblank;
  logic [5:0] rgb;
`ifdef VGA_VBLANK_IRQ_EN
  logic       irq;
  logic       irq_ack = 1'b0;
`endif

  logic [7:0]  ap0 = '0;
  logic [7:0]  ap1 = '0;
  logic [31:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n      = 0;
  int          fs_cnt = 0;
  int          fs_base;

  vga_scaler #(
    .CLK_DIV(2), .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .X_SCALE(3), .Y_SCALE(2), .FB_WIDTH(5), .FB_HEIGHT(5),
    .FB_ADDR_W(8), .BPC(2), .FB_LATENCY(2), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_async(rst_async),
    .en(en),
    .fb_addr(fb_addr),
    .fb_rd(fb_rd),
    .fb_pixel(fb_pixel),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .frame_start(frame_start),
    .vblank(vblank)
`ifdef VGA_VBLANK_IRQ_EN
    ,
    .irq(irq),
    .irq_ack(irq_ack)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // framebuffer RAM model: pixel = addr[5:0] ^ 6'h15, two clocks after the address
  always @(posedge clk) begin
    ap0 <= fb_addr;
    ap1 <= ap0;
  end
  assign fb_pixel = ap1[5:0] ^ 6'h15;
  assign rgb      = {vga_r, vga_g, vga_b};

  always @(negedge clk) if (frame_start) fs_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after rising edge number t (edge 0 = first edge after reset release)
  task automatic goto(input int t);
    while (n < t) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    #12;
    chk("rst_addr", fb_addr, 0);
    chk("rst_rd", fb_rd, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", vga_hsync, 1);
    chk("rst_vsync", vga_vsync, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_vblank", vblank, 0);
    #10;
    rst_async = 1'b0;
    en        = 1'b1;
    @(posedge clk);
    #1;
    n = 0;

    chk("l0_rd_p0", fb_rd, 1);
    chk("l0_addr_p0", fb_addr, 0);
    goto(2);   chk("fs_before", frame_start, 0);
    goto(3);   chk("fs_first", frame_start, 1);
               chk("rgb_p0", rgb, 6'h15);
    goto(4);   chk("fs_after", frame_start, 0);
    goto(5);   chk("l0_addr_p2", fb_addr, 0);
    goto(6);   chk("l0_addr_p3", fb_addr, 1);
    goto(29);  chk("l0_addr_p14", fb_addr, 4);
    goto(30);  chk("border_rd", fb_rd, 0);
               chk("border_addr_hold", fb_addr, 4);
    goto(31);  chk("rgb_p14", rgb, 6'h11);
    goto(32);  chk("blank_rd", fb_rd, 0);
               chk("blank_addr_hold", fb_addr, 4);
    goto(33);  chk("rgb_border", rgb, 0);
    goto(38);  chk("hs_l0_pre", vga_hsync, 1);
    goto(39);  chk("hs_l0_start", vga_hsync, 0);
    goto(44);  chk("hs_l0_last", vga_hsync, 0);
    goto(45);  chk("hs_l0_end", vga_hsync, 1);
    goto(86);  chk("hs_l1_pre", vga_hsync, 1);
    goto(87);  chk("hs_l1_start", vga_hsync, 0);

    // line 2 uses framebuffer row 1
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q = '{5, 5, 5, 6, 6, 6, 7, 7, 7, 8, 8, 8, 9, 9, 9};
    for (int h = 0; h < 15; h++) begin
      goto(96 + 2 * h);
      chk("l2_addr", fb_addr, exp_q.pop_front());
      chk("l2_rd", fb_rd, 1);
    end
    goto(126); chk("l2_border_rd", fb_rd, 0);

    goto(158); chk("rgb_l3_p5", rgb, 6'h13);
    goto(159); chk("rgb_l3_p6", rgb, 6'h12);
    goto(182); chk("hs_l3_pre", vga_hsync, 1);
    goto(183); chk("hs_l3_start", vga_hsync, 0);
    goto(460); chk("l9_addr_p14", fb_addr, 24);
               chk("l9_rd_p14", fb_rd, 1);
    goto(463); chk("rgb_l9_p14", rgb, 6'h0D);
    goto(480); chk("l10_rd", fb_rd, 0);
    goto(483); chk("rgb_bottom_border", rgb, 0);
    goto(578); chk("vblank_pre", vblank, 0);
`ifdef VGA_VBLANK_IRQ_EN
               chk("irq_pre", irq, 0);
`endif
    goto(579); chk("vblank_rise", vblank, 1);
`ifdef VGA_VBLANK_IRQ_EN
               chk("irq_rise", irq, 1);
`endif
    goto(626); chk("vs_pre", vga_vsync, 1);
    goto(627); chk("vs_start", vga_vsync, 0);
    goto(722); chk("vs_last", vga_vsync, 0);
    goto(723); chk("vs_end", vga_vsync, 1);
    goto(816); chk("f2_addr", fb_addr, 0);
               chk("f2_rd", fb_rd, 1);
    goto(818); chk("f2_fs_pre", frame_start, 0);
    goto(819); chk("f2_fs", frame_start, 1);
               chk("f2_vblank", vblank, 0);
    goto(973); chk("f2_rgb_l3_p5", rgb, 6'h13);

    // drop en while hsync is active
    goto(1000); chk("pre_drop_hs", vga_hsync, 0);
    en = 1'b0;
    goto(1001);
    chk("drop_hs", vga_hsync, 1);
    chk("drop_vs", vga_vsync, 1);
    chk("drop_rgb", rgb, 0);
    chk("drop_rd", fb_rd, 0);
    chk("drop_fs", frame_start, 0);
`ifdef VGA_VBLANK_IRQ_EN
    chk("drop_irq", irq, 0);
`endif
    fs_base = fs_cnt;
    goto(1006); chk("idle_rd", fb_rd, 0);
                chk("idle_rgb", rgb, 0);
    en = 1'b1;
    goto(1007); chk("re_addr", fb_addr, 0);
                chk("re_rd", fb_rd, 1);
    goto(1009); chk("re_fs_pre", frame_start, 0);
    goto(1010); chk("re_fs", frame_start, 1);
                chk("re_rgb_p0", rgb, 6'h15);
    goto(1011); chk("re_fs_post", frame_start, 0);
    goto(1030); chk("re_fs_count", fs_cnt - fs_base, 1);
    goto(1045); chk("re_hs_pre", vga_hsync, 1);
    goto(1046); chk("re_hs_start", vga_hsync, 0);

`ifdef VGA_VBLANK_IRQ_EN
    goto(1585); chk("irq2_pre", irq, 0);
    goto(1586); chk("irq2_rise", irq, 1);
                chk("irq2_vblank", vblank, 1);
    goto(1686); chk("irq2_hold", irq, 1);
    irq_ack = 1'b1;
    goto(1687); chk("irq2_acked", irq, 0);
    irq_ack = 1'b0;
    goto(2401); chk("irq3_pre", irq, 0);
    irq_ack = 1'b1;
    goto(2402); chk("irq3_set_wins", irq, 1);
    goto(2403); chk("irq3_acked", irq, 0);
    irq_ack = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
